// File: rtl/gb_bk_pkg.sv
// Shared backup-image definitions for the RTC record streamer: record layout,
// checksum seed, word indices, FSM states and word/checksum helpers.
package gb_bk_pkg;

  localparam int unsigned BK_ADDR_W = 17;
  localparam int unsigned BK_DATA_W = 16;
  localparam int unsigned BK_IDX_W  = 3;

  localparam int unsigned          BK_RTC_WORDS    = 5;
  localparam logic [BK_DATA_W-1:0] BK_RTC_CHK_SEED = 16'h5254;

  // Position of each word inside the RTC record.
  localparam logic [BK_IDX_W-1:0] BK_W_TS_LO = 3'd0;
  localparam logic [BK_IDX_W-1:0] BK_W_TS_HI = 3'd1;
  localparam logic [BK_IDX_W-1:0] BK_W_SV_LO = 3'd2;
  localparam logic [BK_IDX_W-1:0] BK_W_SV_HI = 3'd3;
  localparam logic [BK_IDX_W-1:0] BK_W_CHK   = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SNAP = 2'd1,
    ST_SEND = 2'd2,
    ST_FIN  = 2'd3
  } bk_state_e;

  // Checksum over both halves of both snapshot words.
  function automatic logic [BK_DATA_W-1:0] bk_rtc_chk(
    input logic [BK_DATA_W-1:0] seed,
    input logic [31:0]          ts,
    input logic [31:0]          sv
  );
    return seed ^ ts[15:0] ^ ts[31:16] ^ sv[15:0] ^ sv[31:16];
  endfunction

  // Select record word by index.
  function automatic logic [BK_DATA_W-1:0] bk_rtc_word(
    input logic [BK_IDX_W-1:0]  idx,
    input logic [31:0]          ts,
    input logic [31:0]          sv,
    input logic [BK_DATA_W-1:0] chk
  );
    logic [BK_DATA_W-1:0] w;
    case (idx)
      BK_W_TS_LO: w = ts[15:0];
      BK_W_TS_HI: w = ts[31:16];
      BK_W_SV_LO: w = sv[15:0];
      BK_W_SV_HI: w = sv[31:16];
      BK_W_CHK:   w = chk;
      default:    w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/rtc_bk_streamer.sv
// Snapshots mapper RTC state on start and streams it as a 5-word record
// (ts_lo, ts_hi, sv_lo, sv_hi, chk) into the save image after cart RAM.
// Ports:
//   clk_sys, reset_n              clock, async active-low reset
//   start, abort                  record request / cancel
//   base_addr                     word address of the first record word
//   RTC_inuse                     record only emitted when the cart has an RTC
//   RTC_timestampOut/savedtimeOut RTC state to snapshot
//   bk_addr, bk_data, bk_valid    word offer, held while bk_ready is low
//   bk_ready                      consumer handshake
//   busy, done, skipped           record status
module rtc_bk_streamer
  import gb_bk_pkg::*;
#(
  parameter int unsigned          NWORDS   = BK_RTC_WORDS,
  parameter logic [BK_DATA_W-1:0] CHK_SEED = BK_RTC_CHK_SEED
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [BK_ADDR_W-1:0] base_addr,
  input  logic                 RTC_inuse,
  input  logic [31:0]          RTC_timestampOut,
  input  logic [31:0]          RTC_savedtimeOut,
  output logic [BK_ADDR_W-1:0] bk_addr,
  output logic [BK_DATA_W-1:0] bk_data,
  output logic                 bk_valid,
  input  logic                 bk_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 skipped
);

  localparam logic [BK_IDX_W-1:0] LAST_IDX = BK_IDX_W'(NWORDS - 1);

  bk_state_e            state_q, state_d;
  logic [BK_IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]          ts_q, ts_d, sv_q, sv_d;
  logic [BK_ADDR_W-1:0] base_q, base_d;
  logic [BK_DATA_W-1:0] chk_q, chk_d;
  logic [BK_ADDR_W-1:0] addr_d;
  logic [BK_DATA_W-1:0] data_d;
  logic                 valid_d, busy_d, done_d, skipped_d;
  logic [BK_IDX_W-1:0]  idx_nxt;

  assign idx_nxt = idx_q + BK_IDX_W'(1);

  // State and all registered outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      ts_q     <= '0;
      sv_q     <= '0;
      base_q   <= '0;
      chk_q    <= '0;
      bk_addr  <= '0;
      bk_data  <= '0;
      bk_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      skipped  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ts_q     <= ts_d;
      sv_q     <= sv_d;
      base_q   <= base_d;
      chk_q    <= chk_d;
      bk_addr  <= addr_d;
      bk_data  <= data_d;
      bk_valid <= valid_d;
      busy     <= busy_d;
      done     <= done_d;
      skipped  <= skipped_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ts_d      = ts_q;
    sv_d      = sv_q;
    base_d    = base_q;
    chk_d     = chk_q;
    addr_d    = bk_addr;
    data_d    = bk_data;
    valid_d   = bk_valid;
    busy_d    = busy;
    done_d    = 1'b0;
    skipped_d = skipped;

    case (state_q)
      ST_IDLE: begin
        // abort in the same cycle suppresses the request entirely
        if (start && !abort) begin
          if (RTC_inuse) begin
            ts_d      = RTC_timestampOut;
            sv_d      = RTC_savedtimeOut;
            base_d    = base_addr;
            idx_d     = '0;
            busy_d    = 1'b1;
            skipped_d = 1'b0;
            state_d   = ST_SNAP;
          end else begin
            skipped_d = 1'b1;
            done_d    = 1'b1;
          end
        end
      end

      ST_SNAP: begin
        if (abort) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          chk_d   = bk_rtc_chk(CHK_SEED, ts_q, sv_q);
          addr_d  = base_q;
          data_d  = bk_rtc_word(BK_W_TS_LO, ts_q, sv_q, chk_q);
          valid_d = 1'b1;
          state_d = ST_SEND;
        end
      end

      ST_SEND: begin
        if (abort) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (bk_valid && bk_ready) begin
          if (idx_q == LAST_IDX) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_FIN;
          end else begin
            // next word back-to-back; address wraps modulo 2^17
            idx_d  = idx_nxt;
            addr_d = base_q + BK_ADDR_W'(idx_nxt);
            data_d = bk_rtc_word(idx_nxt, ts_q, sv_q, chk_q);
          end
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rtc_bk_streamer.sv
// Self-checking bench for rtc_bk_streamer: table of per-cycle vectors for the
// nominal, stalled and wrapping records, plus directed skip/snapshot/abort/reset sequences.
module tb_rtc_bk_streamer;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        start, abort;
  logic [16:0] base_addr;
  logic        RTC_inuse;
  logic [31:0] RTC_timestampOut, RTC_savedtimeOut;
  logic [16:0] bk_addr;
  logic [15:0] bk_data;
  logic        bk_valid, bk_ready;
  logic        busy, done, skipped;

  always #5 clk_sys = ~clk_sys;

  rtc_bk_streamer dut (
    .clk_sys          (clk_sys),
    .reset_n          (reset_n),
    .start            (start),
    .abort            (abort),
    .base_addr        (base_addr),
    .RTC_inuse        (RTC_inuse),
    .RTC_timestampOut (RTC_timestampOut),
    .RTC_savedtimeOut (RTC_savedtimeOut),
    .bk_addr          (bk_addr),
    .bk_data          (bk_data),
    .bk_valid         (bk_valid),
    .bk_ready         (bk_ready),
    .busy             (busy),
    .done             (done),
    .skipped          (skipped)
  );

  typedef struct {
    logic        start;
    logic        ready;
    logic [16:0] base;
    logic        ev;
    logic [16:0] ea;
    logic [15:0] ed;
    logic        eb;
    logic        edn;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  localparam logic [31:0] TS = 32'h6543_2100;
  localparam logic [31:0] SV = 32'h0012_3456;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [15:0] exp_word(input int i, input logic [31:0] ts, input logic [31:0] sv);
    logic [15:0] c;
    c = 16'h5254 ^ ts[15:0] ^ ts[31:16] ^ sv[15:0] ^ sv[31:16];
    case (i)
      0: return ts[15:0];
      1: return ts[31:16];
      2: return sv[15:0];
      3: return sv[31:16];
      default: return c;
    endcase
  endfunction

  function automatic vec_t mk(input logic s, input logic r, input logic [16:0] b,
                              input logic ev, input logic [16:0] ea, input logic [15:0] ed,
                              input logic eb, input logic edn);
    vec_t v;
    v.start = s; v.ready = r; v.base = b; v.ev = ev; v.ea = ea; v.ed = ed; v.eb = eb; v.edn = edn;
    return v;
  endfunction

  // Build a record sequence; ready pattern given per row after the start row.
  task automatic add_record(input logic [16:0] b, input logic toggle);
    int  k;
    logic r;
    k = 0;
    vq.push_back(mk(1'b1, 1'b0, b, 1'b0, 17'h0, 16'h0, 1'b1, 1'b0));          // SNAP
    vq.push_back(mk(1'b0, 1'b1, b, 1'b1, b, exp_word(0, TS, SV), 1'b1, 1'b0)); // word 0 shown
    r = toggle ? 1'b0 : 1'b1;
    while (k < 5) begin
      if (r) k++;
      if (k == 5) vq.push_back(mk(1'b0, r, b, 1'b0, 17'h0, 16'h0, 1'b0, 1'b1));
      else vq.push_back(mk(1'b0, r, b, 1'b1, b + 17'(k), exp_word(k, TS, SV), 1'b1, 1'b0));
      if (toggle) r = ~r;
    end
    vq.push_back(mk(1'b0, r, b, 1'b0, 17'h0, 16'h0, 1'b0, 1'b0));
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; RTC_inuse = 1'b1;
    RTC_timestampOut = TS; RTC_savedtimeOut = SV; bk_ready = 1'b1;
    step(); step();
    check("rst addr", 32'(bk_addr), 32'h0);
    check("rst data", 32'(bk_data), 32'h0);
    check("rst valid", 32'(bk_valid), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    check("rst done", 32'(done), 32'h0);
    check("rst skipped", 32'(skipped), 32'h0);
    reset_n = 1'b1;
    step();

    // Table: nominal, stalled 0/1, wrapping base.
    add_record(17'h01000, 1'b0);
    add_record(17'h01000, 1'b1);
    add_record(17'h1FFFE, 1'b0);
    foreach (vq[i]) begin
      start = vq[i].start; bk_ready = vq[i].ready; base_addr = vq[i].base;
      step();
      check($sformatf("vec%0d valid", i), 32'(bk_valid), 32'(vq[i].ev));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(vq[i].eb));
      check($sformatf("vec%0d done", i), 32'(done), 32'(vq[i].edn));
      if (vq[i].ev) begin
        check($sformatf("vec%0d addr", i), 32'(bk_addr), 32'(vq[i].ea));
        check($sformatf("vec%0d data", i), 32'(bk_data), 32'(vq[i].ed));
      end
    end
    start = 1'b0; bk_ready = 1'b1;

    // Skip when no RTC.
    RTC_inuse = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    check("skip valid", 32'(bk_valid), 32'h0);
    check("skip skipped", 32'(skipped), 32'h1);
    check("skip done", 32'(done), 32'h1);
    check("skip busy", 32'(busy), 32'h0);
    step();
    check("skip done pulse", 32'(done), 32'h0);
    check("skip sticky", 32'(skipped), 32'h1);
    check("skip no valid", 32'(bk_valid), 32'h0);
    // start together with abort: nothing happens
    RTC_inuse = 1'b1; start = 1'b1; abort = 1'b1;
    step(); start = 1'b0; abort = 1'b0;
    check("sa busy", 32'(busy), 32'h0);
    check("sa skipped kept", 32'(skipped), 32'h1);
    step();
    check("sa valid", 32'(bk_valid), 32'h0);
    // start with RTC clears skipped; abort in SNAP
    start = 1'b1;
    step(); start = 1'b0;
    check("clr skipped", 32'(skipped), 32'h0);
    check("clr busy", 32'(busy), 32'h1);
    abort = 1'b1;
    step(); abort = 1'b0;
    check("snap abort valid", 32'(bk_valid), 32'h0);
    check("snap abort busy", 32'(busy), 32'h0);
    check("snap abort done", 32'(done), 32'h0);
    step();
    check("snap abort idle", 32'(busy), 32'h0);

    // Snapshot isolation and start during SEND.
    RTC_timestampOut = 32'hDEAD_BEEF; RTC_savedtimeOut = 32'hCAFE_F00D; base_addr = 17'h00200;
    start = 1'b1;
    step(); start = 1'b0;
    RTC_timestampOut = 32'h1111_2222; RTC_savedtimeOut = 32'h3333_4444; base_addr = 17'h1ABCD;
    step();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("snap w%0d addr", k), 32'(bk_addr), 32'(17'h00200 + 17'(k)));
      check($sformatf("snap w%0d data", k), 32'(bk_data), 32'(exp_word(k, 32'hDEAD_BEEF, 32'hCAFE_F00D)));
      start = (k == 1);
      step();
    end
    start = 1'b0;
    check("snap done", 32'(done), 32'h1);
    check("snap valid end", 32'(bk_valid), 32'h0);
    step();
    check("snap done once", 32'(done), 32'h0);
    step();
    check("snap no restart busy", 32'(busy), 32'h0);
    check("snap no restart valid", 32'(bk_valid), 32'h0);

    // Abort after word 2 accepted.
    RTC_timestampOut = TS; RTC_savedtimeOut = SV; base_addr = 17'h00040;
    start = 1'b1;
    step(); start = 1'b0;
    step(); step(); step(); step();
    check("abort at w3 addr", 32'(bk_addr), 32'h00043);
    check("abort at w3 data", 32'(bk_data), 32'(exp_word(3, TS, SV)));
    abort = 1'b1;
    step(); abort = 1'b0;
    check("abort valid", 32'(bk_valid), 32'h0);
    check("abort busy", 32'(busy), 32'h0);
    check("abort done", 32'(done), 32'h0);
    step();
    check("abort no done", 32'(done), 32'h0);
    check("abort idle valid", 32'(bk_valid), 32'h0);

    // Reset mid-record at word 3.
    start = 1'b1;
    step(); start = 1'b0;
    step(); step(); step(); step();
    check("rstmid w3 addr", 32'(bk_addr), 32'h00043);
    reset_n = 1'b0;
    #1;
    check("rstmid addr", 32'(bk_addr), 32'h0);
    check("rstmid data", 32'(bk_data), 32'h0);
    check("rstmid valid", 32'(bk_valid), 32'h0);
    check("rstmid busy", 32'(busy), 32'h0);
    check("rstmid done", 32'(done), 32'h0);
    step();
    reset_n = 1'b1;
    step();
    check("rstmid after done", 32'(done), 32'h0);
    check("rstmid after busy", 32'(busy), 32'h0);
    check("rstmid after valid", 32'(bk_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
